// File: rtl/kn_fifo_writer.sv
// kn_fifo_writer: spreads incoming KN rows round-robin over PARA_BLOCKS FIFOs,
// zero-padding a short final group so every transfer ends on a lane boundary.
module kn_fifo_writer #(
  parameter int NUM_PES          = 16,
  parameter int DATA_TYPE        = 16,
  parameter int PARA_BLOCKS      = 4,
  parameter int LOG2_PARA_BLOCKS = 2,
  parameter int ROW_CNT_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_start,
  input  logic                           i_KN_valid,
  input  logic [DATA_TYPE*NUM_PES-1:0]   i_KN_data,
  input  logic                           i_KN_last,
  output logic                           o_KN_ready,
  input  logic [PARA_BLOCKS-1:0]         i_fifo_KN_full,
  output logic [PARA_BLOCKS-1:0]         o_fifo_KN_wr_en,
  output logic [DATA_TYPE*NUM_PES-1:0]   o_fifo_KN_data_in,
  output logic [ROW_CNT_W-1:0]           o_row_count,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int ROW_W = DATA_TYPE * NUM_PES;
  localparam logic [LOG2_PARA_BLOCKS-1:0] LAST_LANE = LOG2_PARA_BLOCKS'(PARA_BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, FILL, PAD} state_t;

  state_t                      r_state;
  logic [LOG2_PARA_BLOCKS-1:0] r_wr_ptr;
  logic [PARA_BLOCKS-1:0]      r_wr_en;
  logic [ROW_W-1:0]            r_data;
  logic [ROW_CNT_W-1:0]        r_row_count;
  logic                        r_done;

  logic [PARA_BLOCKS-1:0]      w_lane_sel;
  logic [LOG2_PARA_BLOCKS-1:0] w_ptr_next;
  logic                        w_lane_full;
  logic                        w_at_last_lane;
  logic                        w_accept;

  // One-hot decode of the pointer; doubles as the write strobe and the full-flag select.
  always_comb begin
    w_lane_sel = '0;
    for (int i = 0; i < PARA_BLOCKS; i++) begin
      if (r_wr_ptr == LOG2_PARA_BLOCKS'(i)) w_lane_sel[i] = 1'b1;
    end
  end

  assign w_lane_full    = |(i_fifo_KN_full & w_lane_sel);
  assign w_at_last_lane = (r_wr_ptr == LAST_LANE);
  assign w_ptr_next     = w_at_last_lane ? '0 : r_wr_ptr + LOG2_PARA_BLOCKS'(1);
  assign o_KN_ready     = (r_state == FILL) && !w_lane_full;
  assign w_accept       = i_KN_valid && o_KN_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_wr_en     <= '0;
      r_data      <= '0;
      r_row_count <= '0;
      r_done      <= 1'b0;
    end else begin
      r_wr_en <= '0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state     <= FILL;
            r_wr_ptr    <= '0;
            r_row_count <= '0;
          end
        end
        FILL: begin
          if (w_accept) begin
            r_data      <= i_KN_data;
            r_wr_en     <= w_lane_sel;
            r_row_count <= r_row_count + ROW_CNT_W'(1);
            r_wr_ptr    <= w_ptr_next;
            // A last row on the final lane closes the group; otherwise pad it out.
            if (i_KN_last) begin
              if (w_at_last_lane) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
              end else begin
                r_state <= PAD;
              end
            end
          end
        end
        PAD: begin
          if (!w_lane_full) begin
            r_data   <= '0;
            r_wr_en  <= w_lane_sel;
            r_wr_ptr <= w_ptr_next;
            if (w_at_last_lane) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_fifo_KN_wr_en   = r_wr_en;
  assign o_fifo_KN_data_in = r_data;
  assign o_row_count       = r_row_count;
  assign o_done            = r_done;
  assign o_busy            = (r_state != IDLE);

endmodule

// File: tb/tb_kn_fifo_writer.sv
// tb_kn_fifo_writer: scenario tasks plus randomized transfers, scored against a
// count-based model of the round-robin/pad behaviour.
module tb_kn_fifo_writer;

  localparam int P  = 4;
  localparam int W  = 256;
  localparam int RC = 16;

  typedef struct packed {
    logic [P-1:0]  en;
    logic [W-1:0]  data;
    logic          done;
    logic [31:0]   cyc;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, valid, last;
  logic [W-1:0]  data;
  logic [P-1:0]  full;
  logic          o_KN_ready, o_busy, o_done;
  logic [P-1:0]  o_fifo_KN_wr_en;
  logic [W-1:0]  o_fifo_KN_data_in;
  logic [RC-1:0] o_row_count;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 0;

  // Model: a transfer is just counts of accepted rows and issued writes.
  bit  m_busy = 0, m_pad = 0;
  int  m_acc = 0, m_wr = 0;
  wr_t exp_q[$];
  wr_t obs_q[$];

  kn_fifo_writer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_start           (start),
    .i_KN_valid        (valid),
    .i_KN_data         (data),
    .i_KN_last         (last),
    .o_KN_ready        (o_KN_ready),
    .i_fifo_KN_full    (full),
    .o_fifo_KN_wr_en   (o_fifo_KN_wr_en),
    .o_fifo_KN_data_in (o_fifo_KN_data_in),
    .o_row_count       (o_row_count),
    .o_busy            (o_busy),
    .o_done            (o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_fifo_KN_wr_en != '0 || o_done) begin
      wr_t o;
      o.en = o_fifo_KN_wr_en; o.data = o_fifo_KN_data_in; o.done = o_done; o.cyc = cyc;
      obs_q.push_back(o);
    end
  end

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit exp_ready();
    return m_busy && !m_pad && !full[m_wr % P];
  endfunction

  task automatic push_exp(input int lane, input logic [W-1:0] d, input bit dn);
    wr_t e;
    logic [P-1:0] one;
    one = 1;
    e.en = one << lane; e.data = d; e.done = dn; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Row i of a transfer lands in lane i mod P; pad rows fill up to the next multiple of P.
  task automatic model_step();
    int lane;
    lane = m_wr % P;
    if (!m_busy) begin
      if (start) begin m_busy = 1; m_pad = 0; m_acc = 0; m_wr = 0; end
    end else if (!m_pad) begin
      if (valid && !full[lane]) begin
        push_exp(lane, data, last && (lane == P - 1));
        m_acc++; m_wr++;
        if (last) begin
          if (m_wr % P == 0) m_busy = 0; else m_pad = 1;
        end
      end
    end else if (!full[lane]) begin
      push_exp(lane, '0, lane == P - 1);
      m_wr++;
      if (m_wr % P == 0) begin m_pad = 0; m_busy = 0; end
    end
  endtask

  task automatic drive(input logic s, input logic v, input logic [W-1:0] d,
                       input logic l, input logic [P-1:0] f);
    @(negedge clk);
    start = s; valid = v; data = d; last = l; full = f;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; valid = 0; last = 0; data = '0; full = '0;
    #3;
    checks++;
    if (o_fifo_KN_wr_en !== '0 || o_fifo_KN_data_in !== '0)
      begin errors++; $display("[TB] FAIL reset_wr: got en=%b data=%h, expected 0", o_fifo_KN_wr_en, o_fifo_KN_data_in); end
    checks++;
    if (o_row_count !== '0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_KN_ready !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_ctl: got cnt=%0d busy=%b done=%b rdy=%b, expected 0", o_row_count, o_busy, o_done, o_KN_ready); end
    @(negedge clk); rst_n = 1'b1;
    drive(0, 1, rand_row(), 0, '0);
    drive(0, 1, rand_row(), 0, '0);
    checks++;
    if (o_busy !== 1'b0 || o_KN_ready !== 1'b0 || obs_q.size() != 0)
      begin errors++; $display("[TB] FAIL idle_after_reset: got busy=%b rdy=%b writes=%0d, expected 0 0 0", o_busy, o_KN_ready, obs_q.size()); end
    valid = 0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_groups();
    logic [W-1:0] rows[$];
    logic [W-1:0] d;
    int idx; bit v, acc; wr_t e, o;
    for (int i = 1; i <= 8; i++) rows.push_back(W'(i));
    drive(1, 0, '0, 0, '0); tick();
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("[TB] FAIL full_groups busy_rise: got %b, expected 1", o_busy); end
    idx = 0;
    for (int c = 0; c < 100 && m_busy; c++) begin
      v = idx < 8; d = '0; if (v) d = rows[idx];
      drive(0, v, d, v && idx == 7, '0);
      checks++;
      if (o_KN_ready !== exp_ready()) begin errors++; $display("[TB] FAIL full_groups ready: got %b, expected %b", o_KN_ready, exp_ready()); end
      acc = v && exp_ready(); tick(); if (acc) idx++;
      checks++;
      if (o_row_count !== RC'(m_acc) || o_busy !== m_busy)
        begin errors++; $display("[TB] FAIL full_groups count: got cnt=%0d busy=%b, expected cnt=%0d busy=%b", o_row_count, o_busy, m_acc, m_busy); end
    end
    checks++;
    if (m_busy) begin errors++; $display("[TB] FAIL full_groups timeout: got busy, expected transfer complete"); end
    drive(0, 0, '0, 0, '0); drive(0, 0, '0, 0, '0);
    checks++;
    if (o_row_count !== RC'(8) || o_fifo_KN_data_in !== W'(8))
      begin errors++; $display("[TB] FAIL full_groups final: got cnt=%0d data=%h, expected 8 and held row 8", o_row_count, o_fifo_KN_data_in); end
    checks++;
    if (obs_q.size() != 8 || obs_q[7].en !== 4'b1000 || obs_q[7].done !== 1'b1 || obs_q[7].cyc != obs_q[0].cyc + 7)
      begin errors++; $display("[TB] FAIL full_groups shape: got %0d writes, expected 8 back-to-back ending lane 3 with done", obs_q.size()); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL full_groups nwrites: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL full_groups write: got en=%b done=%b cyc=%0d data=%h, expected en=%b done=%b cyc=%0d data=%h", o.en, o.done, o.cyc, o.data, e.en, e.done, e.cyc, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_pad();
    logic [W-1:0] rows[$];
    logic [W-1:0] d;
    int idx; bit v, acc; wr_t e, o;
    for (int i = 0; i < 6; i++) rows.push_back(rand_row());
    drive(1, 0, '0, 0, '0); tick();
    idx = 0;
    for (int c = 0; c < 100 && m_busy; c++) begin
      v = idx < 6; d = '0; if (v) d = rows[idx];
      drive(0, v, d, v && idx == 5, '0);
      checks++;
      if (o_KN_ready !== exp_ready()) begin errors++; $display("[TB] FAIL pad ready: got %b, expected %b", o_KN_ready, exp_ready()); end
      acc = v && exp_ready(); tick(); if (acc) idx++;
      checks++;
      if (o_row_count !== RC'(m_acc) || o_busy !== m_busy)
        begin errors++; $display("[TB] FAIL pad count: got cnt=%0d busy=%b, expected cnt=%0d busy=%b", o_row_count, o_busy, m_acc, m_busy); end
    end
    checks++;
    if (m_busy) begin errors++; $display("[TB] FAIL pad timeout: got busy, expected transfer complete"); end
    drive(0, 0, '0, 0, '0);
    checks++;
    if (o_row_count !== RC'(6) || obs_q.size() != 8 || obs_q[7].en !== 4'b1000 || obs_q[7].data !== '0 || obs_q[7].done !== 1'b1)
      begin errors++; $display("[TB] FAIL pad shape: got cnt=%0d writes=%0d, expected cnt=6 and 8 writes ending with zero row on lane 3", o_row_count, obs_q.size()); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL pad nwrites: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL pad write: got en=%b done=%b cyc=%0d data=%h, expected en=%b done=%b cyc=%0d data=%h", o.en, o.done, o.cyc, o.data, e.en, e.done, e.cyc, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] rows[$];
    logic [W-1:0] d;
    int idx; bit v, acc; wr_t e, o;
    for (int i = 0; i < 5; i++) rows.push_back(rand_row());
    drive(1, 0, '0, 0, '0); tick();
    idx = 0;
    for (int c = 0; c < 100 && m_busy; c++) begin
      v = idx < 5; d = '0; if (v) d = rows[idx];
      drive(0, v, d, v && idx == 4, (c < 5) ? 4'b0100 : 4'b0000);
      checks++;
      if (o_KN_ready !== exp_ready()) begin errors++; $display("[TB] FAIL backpressure ready: got %b, expected %b", o_KN_ready, exp_ready()); end
      if (c == 3) begin
        checks++;
        if (o_KN_ready !== 1'b0 || o_row_count !== RC'(2))
          begin errors++; $display("[TB] FAIL backpressure stall: got rdy=%b cnt=%0d, expected rdy=0 cnt=2", o_KN_ready, o_row_count); end
      end
      acc = v && exp_ready(); tick(); if (acc) idx++;
      checks++;
      if (o_row_count !== RC'(m_acc) || o_busy !== m_busy)
        begin errors++; $display("[TB] FAIL backpressure count: got cnt=%0d busy=%b, expected cnt=%0d busy=%b", o_row_count, o_busy, m_acc, m_busy); end
    end
    checks++;
    if (m_busy) begin errors++; $display("[TB] FAIL backpressure timeout: got busy, expected transfer complete"); end
    drive(0, 0, '0, 0, '0);
    checks++;
    if (obs_q.size() != 8 || obs_q[2].en !== 4'b0100 || obs_q[2].data !== rows[2])
      begin errors++; $display("[TB] FAIL backpressure row3: got %0d writes, expected 8 with row 3 in lane 2", obs_q.size()); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL backpressure nwrites: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL backpressure write: got en=%b done=%b cyc=%0d data=%h, expected en=%b done=%b cyc=%0d data=%h", o.en, o.done, o.cyc, o.data, e.en, e.done, e.cyc, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_pad_full();
    logic [W-1:0] rows[$];
    logic [W-1:0] d;
    int idx, hold; bit v, acc; wr_t e, o;
    logic [P-1:0] f;
    for (int i = 0; i < 5; i++) rows.push_back(rand_row());
    drive(1, 0, '0, 0, '0); tick();
    idx = 0; hold = 0;
    for (int c = 0; c < 100 && m_busy; c++) begin
      v = idx < 5; d = '0; if (v) d = rows[idx];
      f = '0;
      if (m_pad && hold < 3) begin f = 4'b0010; hold++; end
      drive(0, v, d, v && idx == 4, f);
      checks++;
      if (o_KN_ready !== exp_ready()) begin errors++; $display("[TB] FAIL pad_full ready: got %b, expected %b", o_KN_ready, exp_ready()); end
      acc = v && exp_ready(); tick(); if (acc) idx++;
      checks++;
      if (o_row_count !== RC'(m_acc) || o_busy !== m_busy)
        begin errors++; $display("[TB] FAIL pad_full count: got cnt=%0d busy=%b, expected cnt=%0d busy=%b", o_row_count, o_busy, m_acc, m_busy); end
    end
    checks++;
    if (m_busy) begin errors++; $display("[TB] FAIL pad_full timeout: got busy, expected transfer complete"); end
    drive(0, 0, '0, 0, '0);
    checks++;
    if (obs_q.size() != 8 || obs_q[5].en !== 4'b0010 || obs_q[5].cyc != obs_q[4].cyc + 4 || obs_q[7].cyc != obs_q[4].cyc + 6)
      begin errors++; $display("[TB] FAIL pad_full delay: got %0d writes, expected lane-1 pad 4 cycles after last row then lanes 2,3", obs_q.size()); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL pad_full nwrites: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL pad_full write: got en=%b done=%b cyc=%0d data=%h, expected en=%b done=%b cyc=%0d data=%h", o.en, o.done, o.cyc, o.data, e.en, e.done, e.cyc, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] rows[$];
    logic [W-1:0] d;
    int idx; bit v, acc; wr_t e, o;
    for (int i = 0; i < 8; i++) rows.push_back(rand_row());
    drive(1, 0, '0, 0, '0); tick();
    idx = 0;
    for (int c = 0; c < 50 && idx < 3; c++) begin
      d = rows[idx];
      drive(0, 1, d, 0, '0);
      checks++;
      if (o_KN_ready !== exp_ready()) begin errors++; $display("[TB] FAIL reset_mid ready: got %b, expected %b", o_KN_ready, exp_ready()); end
      acc = exp_ready(); tick(); if (acc) idx++;
    end
    checks++;
    if (idx != 3) begin errors++; $display("[TB] FAIL reset_mid timeout: got %0d rows accepted, expected 3", idx); end
    #2 rst_n = 1'b0; valid = 0;
    #1;
    checks++;
    if (o_fifo_KN_wr_en !== '0 || o_fifo_KN_data_in !== '0)
      begin errors++; $display("[TB] FAIL reset_mid wr: got en=%b data=%h, expected 0", o_fifo_KN_wr_en, o_fifo_KN_data_in); end
    checks++;
    if (o_row_count !== '0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_KN_ready !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_mid ctl: got cnt=%0d busy=%b done=%b rdy=%b, expected 0", o_row_count, o_busy, o_done, o_KN_ready); end
    if (exp_q.size() > 0) e = exp_q.pop_back();
    m_busy = 0; m_pad = 0; m_acc = 0; m_wr = 0;
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL reset_mid nwrites: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL reset_mid write: got en=%b done=%b cyc=%0d data=%h, expected en=%b done=%b cyc=%0d data=%h", o.en, o.done, o.cyc, o.data, e.en, e.done, e.cyc, e.data); end
    end
    exp_q.delete(); obs_q.delete();
    drive(1, 0, '0, 0, '0); tick();
    idx = 0;
    for (int c = 0; c < 50 && m_busy; c++) begin
      v = idx < 2; d = '0; if (v) d = rows[idx + 3];
      drive(0, v, d, v && idx == 1, '0);
      acc = v && exp_ready(); tick(); if (acc) idx++;
    end
    drive(0, 0, '0, 0, '0);
    checks++;
    if (obs_q.size() != 4 || obs_q[0].en !== 4'b0001 || obs_q[0].data !== rows[3] || o_row_count !== RC'(2))
      begin errors++; $display("[TB] FAIL reset_mid restart: got %0d writes cnt=%0d, expected 4 writes from lane 0 cnt=2", obs_q.size(), o_row_count); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL reset_mid restart nwrites: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL reset_mid restart write: got en=%b done=%b cyc=%0d data=%h, expected en=%b done=%b cyc=%0d data=%h", o.en, o.done, o.cyc, o.data, e.en, e.done, e.cyc, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overlap();
    logic [W-1:0] rows[$];
    logic [W-1:0] d;
    int idx; bit v, acc; wr_t e, o;
    for (int i = 0; i < 4; i++) rows.push_back(rand_row());
    drive(1, 1, rows[0], 0, '0);
    checks++;
    if (o_KN_ready !== 1'b0) begin errors++; $display("[TB] FAIL overlap idle_ready: got %b, expected 0", o_KN_ready); end
    tick();
    idx = 0;
    for (int c = 0; c < 100 && m_busy; c++) begin
      v = idx < 4; d = '0; if (v) d = rows[idx];
      drive(c == 1, v, d, v && idx == 3, '0);
      checks++;
      if (o_KN_ready !== exp_ready()) begin errors++; $display("[TB] FAIL overlap ready: got %b, expected %b", o_KN_ready, exp_ready()); end
      acc = v && exp_ready(); tick(); if (acc) idx++;
      checks++;
      if (o_row_count !== RC'(m_acc) || o_busy !== m_busy)
        begin errors++; $display("[TB] FAIL overlap count: got cnt=%0d busy=%b, expected cnt=%0d busy=%b", o_row_count, o_busy, m_acc, m_busy); end
    end
    drive(0, 0, '0, 0, '0);
    checks++;
    if (obs_q.size() != 4 || obs_q[0].en !== 4'b0001 || obs_q[0].data !== rows[0] || obs_q[3].en !== 4'b1000 || o_row_count !== RC'(4))
      begin errors++; $display("[TB] FAIL overlap shape: got %0d writes cnt=%0d, expected 4 writes lanes 0..3 cnt=4", obs_q.size(), o_row_count); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL overlap nwrites: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("[TB] FAIL overlap write: got en=%b done=%b cyc=%0d data=%h, expected en=%b done=%b cyc=%0d data=%h", o.en, o.done, o.cyc, o.data, e.en, e.done, e.cyc, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    logic [W-1:0] rows[$];
    logic [W-1:0] d;
    logic [P-1:0] f;
    int idx, n; bit v, s, acc; wr_t e, o;
    for (int t = 0; t < 6; t++) begin
      rows.delete();
      n = $urandom_range(1, 11);
      for (int i = 0; i < n; i++) rows.push_back(rand_row());
      drive(1, 1'($urandom_range(0, 1)), rand_row(), 0, '0);
      checks++;
      if (o_KN_ready !== exp_ready()) begin errors++; $display("[TB] FAIL random start_ready: got %b, expected %b", o_KN_ready, exp_ready()); end
      tick();
      idx = 0;
      for (int c = 0; c < 400 && m_busy; c++) begin
        v = (idx < n) && ($urandom_range(0, 3) != 0);
        d = '0; if (idx < n) d = rows[idx];
        for (int b = 0; b < P; b++) f[b] = ($urandom_range(0, 3) == 0);
        s = ($urandom_range(0, 7) == 0);
        drive(s, v, d, v && idx == n - 1, f);
        checks++;
        if (o_KN_ready !== exp_ready()) begin errors++; $display("[TB] FAIL random ready: got %b, expected %b", o_KN_ready, exp_ready()); end
        acc = v && exp_ready(); tick(); if (acc) idx++;
        checks++;
        if (o_row_count !== RC'(m_acc) || o_busy !== m_busy)
          begin errors++; $display("[TB] FAIL random count: got cnt=%0d busy=%b, expected cnt=%0d busy=%b", o_row_count, o_busy, m_acc, m_busy); end
      end
      checks++;
      if (m_busy) begin errors++; $display("[TB] FAIL random timeout: transfer %0d still busy", t); end
      drive(0, 0, '0, 0, '0);
      checks++;
      if (obs_q.size() != ((n + P - 1) / P) * P || o_row_count !== RC'(n))
        begin errors++; $display("[TB] FAIL random group: got %0d writes cnt=%0d, expected %0d writes cnt=%0d", obs_q.size(), o_row_count, ((n + P - 1) / P) * P, n); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL random nwrites: got %0d, expected %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
        if (o !== e) begin errors++; $display("[TB] FAIL random write: got en=%b done=%b cyc=%0d data=%h, expected en=%b done=%b cyc=%0d data=%h", o.en, o.done, o.cyc, o.data, e.en, e.done, e.cyc, e.data); end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_full_groups();
    test_pad();
    test_backpressure();
    test_pad_full();
    test_reset_mid();
    test_overlap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kn_fifo_writer.md
# kn_fifo_writer

Write-side companion of the KN read buffer. Accepts a stream of KN rows (one `NUM_PES`-wide row per beat) from the loader and distributes them round-robin into the `PARA_BLOCKS` parallel KN FIFOs, starting at lane 0. The read side consumes these FIFOs with a wrapping lane counter, so the writer keeps every transfer group aligned to `PARA_BLOCKS` rows. A short final group is zero-padded to the group boundary.

## Interface
- `NUM_PES`, 16, PEs per PEG; row width is `NUM_PES * DATA_TYPE`.
- `DATA_TYPE`, 16, bits per element.
- `PARA_BLOCKS`, 4, number of parallel KN FIFOs; must be ≥ 2.
- `LOG2_PARA_BLOCKS`, 2, ceil(log2(`PARA_BLOCKS`)).
- `ROW_CNT_W`, 16, width of the accepted-row counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: one-cycle pulse that begins a transfer; ignored unless in IDLE.
- `i_KN_valid` in 1: input row valid.
- `i_KN_data` in `DATA_TYPE*NUM_PES`: input row.
- `i_KN_last` in 1: marks the final row of a transfer; qualified by valid & ready.
- `o_KN_ready` out 1: the writer can accept a row this cycle.
- `i_fifo_KN_full` in `PARA_BLOCKS`: per-lane FIFO full flags.
- `o_fifo_KN_wr_en` out `PARA_BLOCKS`: registered, one-hot-or-zero write strobe.
- `o_fifo_KN_data_in` out `DATA_TYPE*NUM_PES`: registered row, shared by all lanes.
- `o_row_count` out `ROW_CNT_W`: number of rows accepted since `i_start`; excludes pad rows; wraps on overflow.
- `o_busy` out 1: high whenever the state is not IDLE.
- `o_done` out 1: one-cycle pulse when a transfer completes.

## Operation
**States.** There are three states: IDLE, FILL and PAD.

- **IDLE**
  - `o_KN_ready` = 0.
  - `i_start` → FILL. On entry, `wr_ptr` = 0 and `o_row_count` = 0.
- **FILL**
  - `o_KN_ready = !i_fifo_KN_full[wr_ptr]`.
  - On accept (`i_KN_valid & o_KN_ready`):
    - Register the row.
    - Assert `o_fifo_KN_wr_en[wr_ptr]` next cycle.
    - Increment `o_row_count`.
    - Advance `wr_ptr` (at `PARA_BLOCKS-1` it wraps to 0).
  - Accepted with `i_KN_last` and `wr_ptr == PARA_BLOCKS-1` → IDLE, with `o_done` asserted on the write cycle.
  - Accepted with `i_KN_last` and `wr_ptr < PARA_BLOCKS-1` → PAD.
- **PAD**
  - `o_KN_ready` = 0.
  - Each cycle where `!i_fifo_KN_full[wr_ptr]`: write an all-zero row to lane `wr_ptr`, then advance the pointer.
  - After writing lane `PARA_BLOCKS-1` → IDLE, `wr_ptr` = 0, `o_done` asserted on that write cycle.

**Pointer.**
- `wr_ptr` is `LOG2_PARA_BLOCKS` bits wide.
- It wraps explicitly by compare against `PARA_BLOCKS-1`, so non-power-of-two `PARA_BLOCKS` works.

**Outputs.**
- At most one `o_fifo_KN_wr_en` bit is high per cycle.
- `o_fifo_KN_data_in` holds its previous value when no write is issued.

**Full handling.**
- Ready is derived from `i_fifo_KN_full[wr_ptr]` in the cycle of acceptance.
- Writes to the same lane are ≥ `PARA_BLOCKS` ≥ 2 cycles apart, so the full flag has updated before that lane is written again.
- No extra margin is required.

**Simultaneous events.**
- `i_start` together with `i_KN_valid` in IDLE: the row is not accepted, because ready is 0 in IDLE.
- `i_start` in FILL or PAD: ignored.
- `i_KN_valid` in PAD: held off (ready = 0).

## Timing
- **Reset values.** On `rst_n` low, immediately (asynchronous):
  - state = IDLE, `wr_ptr` = 0;
  - `o_fifo_KN_wr_en` = 0, `o_fifo_KN_data_in` = 0;
  - `o_row_count` = 0, `o_busy` = 0, `o_done` = 0.
- **Reset mid-transfer.** A pending registered write is dropped and no pad rows are issued.
- **Latency.** Accept at edge N → `o_fifo_KN_wr_en` and data valid during cycle N+1.
- **Throughput.** One row per cycle when no targeted lane is full.
- **`o_busy`.** Rises the cycle after `i_start`. Falls the cycle after the final write is issued.
- **`o_done`.** Coincides with the final `o_fifo_KN_wr_en` pulse.
- **`o_row_count`.** Updates on the accept edge, so it is visible in cycle N+1.

## Test plan
1. **Full groups, no pad.** Defaults; `i_start`, then 8 back-to-back rows with values 1..8, `last` on row 8.
   - Writes go to lanes 0,1,2,3,0,1,2,3 on consecutive cycles with data 1..8.
   - `o_done` coincides with the 8th write; `o_row_count` = 8; no pad writes.
2. **Short final group, PAD.** 6 rows, `last` on row 6.
   - Rows land in lanes 0,1,2,3,0,1.
   - Then zero rows are written to lanes 2 and 3 on the next 2 cycles.
   - `o_done` coincides with the lane-3 zero write; `o_row_count` = 6; ready = 0 during PAD.
3. **Backpressure.** Hold `i_fifo_KN_full[2]` = 1 for 5 cycles while valid is held.
   - Rows 1–2 are accepted, then ready = 0 with `wr_ptr` = 2.
   - After the flag is released, row 3 goes to lane 2 with no row lost or duplicated.
4. **Full during PAD.** Last row accepted at lane 0; `i_fifo_KN_full[1]` = 1 for 3 cycles.
   - The pad write to lane 1 is delayed until the flag is released, then lanes 1,2,3 are padded in sequence.
5. **Reset mid-transfer.** Drop `rst_n` one cycle after accepting row 3 of 8.
   - `o_fifo_KN_wr_en` goes to 0 immediately and all outputs take their reset values.
   - A new `i_start` begins again at lane 0.
6. **Start/valid overlap and spurious start.** `i_start` and `i_KN_valid` high in the same IDLE cycle.
   - The row is not accepted that cycle; it is accepted the next cycle into lane 0.
   - A second `i_start` pulse during FILL has no effect on `wr_ptr` or `o_row_count`.
